name_suite_vec_mem_responder: RTL and testbench

NAME_SUITE_VEC_MEM_RESPONDER -- requirements
Module: name_suite_vec_mem_responder

---
 rtl/name_suite_vec_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_name_suite_vec_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/name_suite_vec_mem_responder.sv
// Four-port round-robin front end that funnels one request at a time to a single memory
// port and returns the memory's answer to the requestor that was granted.
module name_suite_vec_mem_responder #(
    parameter int N  = 4,
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          io_requestor_0_req_valid,
    output logic          io_requestor_0_req_ready,
    input  logic [AW-1:0] io_requestor_0_req_bits_addr,
    output logic          io_requestor_0_resp_valid,
    output logic [DW-1:0] io_requestor_0_resp_bits_data,

    input  logic          io_requestor_1_req_valid,
    output logic          io_requestor_1_req_ready,
    input  logic [AW-1:0] io_requestor_1_req_bits_addr,
    output logic          io_requestor_1_resp_valid,
    output logic [DW-1:0] io_requestor_1_resp_bits_data,

    input  logic          io_requestor_2_req_valid,
    output logic          io_requestor_2_req_ready,
    input  logic [AW-1:0] io_requestor_2_req_bits_addr,
    output logic          io_requestor_2_resp_valid,
    output logic [DW-1:0] io_requestor_2_resp_bits_data,

    input  logic          io_requestor_3_req_valid,
    output logic          io_requestor_3_req_ready,
    input  logic [AW-1:0] io_requestor_3_req_bits_addr,
    output logic          io_requestor_3_resp_valid,
    output logic [DW-1:0] io_requestor_3_resp_bits_data,

    output logic          io_mem_req_valid,
    input  logic          io_mem_req_ready,
    output logic [AW-1:0] io_mem_req_bits_addr,
    input  logic          io_mem_resp_valid,
    input  logic [DW-1:0] io_mem_resp_bits_data,

    output logic          io_busy
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [N-1:0]  req_valid_vec;
    logic [N-1:0]  req_ready_vec;
    logic [AW-1:0] req_addr [N];

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          resp_strobe;

    logic          found;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;
    logic          accept;
    logic          capture;

    assign req_valid_vec = {io_requestor_3_req_valid, io_requestor_2_req_valid,
                            io_requestor_1_req_valid, io_requestor_0_req_valid};
    assign req_addr[0]   = io_requestor_0_req_bits_addr;
    assign req_addr[1]   = io_requestor_1_req_bits_addr;
    assign req_addr[2]   = io_requestor_2_req_bits_addr;
    assign req_addr[3]   = io_requestor_3_req_bits_addr;

    // Search starts one past the last winner; the last candidate checked is ptr itself.
    always_comb begin
        found     = 1'b0;
        grant_idx = ptr;
        cand      = ptr;
        for (int i = 1; i <= N; i++) begin
            cand = ptr + IW'(i);
            if (!found && req_valid_vec[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        req_ready_vec    = '0;
        io_mem_req_valid = 1'b0;
        accept           = 1'b0;
        capture          = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready_vec[grant_idx] = 1'b1;
                    accept                   = 1'b1;
                    state_next               = ISSUE;
                end
            end
            ISSUE: begin
                io_mem_req_valid = 1'b1;
                if (io_mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (io_mem_resp_valid) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // idx is only overwritten by a new grant, so it still names the answered port
    // during the strobe cycle even when that cycle grants again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= IW'(N - 1);
            idx         <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_strobe <= 1'b0;
        end else begin
            resp_strobe <= capture;
            if (accept) begin
                ptr    <= grant_idx;
                idx    <= grant_idx;
                addr_q <= req_addr[grant_idx];
            end
            if (capture) begin
                data_q <= io_mem_resp_bits_data;
            end
        end
    end

    assign io_requestor_0_req_ready = req_ready_vec[0];
    assign io_requestor_1_req_ready = req_ready_vec[1];
    assign io_requestor_2_req_ready = req_ready_vec[2];
    assign io_requestor_3_req_ready = req_ready_vec[3];

    assign io_requestor_0_resp_valid = resp_strobe && (idx == IW'(0));
    assign io_requestor_1_resp_valid = resp_strobe && (idx == IW'(1));
    assign io_requestor_2_resp_valid = resp_strobe && (idx == IW'(2));
    assign io_requestor_3_resp_valid = resp_strobe && (idx == IW'(3));

    assign io_requestor_0_resp_bits_data = data_q;
    assign io_requestor_1_resp_bits_data = data_q;
    assign io_requestor_2_resp_bits_data = data_q;
    assign io_requestor_3_resp_bits_data = data_q;

    assign io_mem_req_bits_addr = addr_q;
    assign io_busy              = (state != IDLE);

endmodule

// File: tb/tb_name_suite_vec_mem_responder.sv
// Directed, table-driven bench for name_suite_vec_mem_responder: one record per clock
// cycle holding the inputs for that cycle and the outputs expected during it.
module tb_name_suite_vec_mem_responder;

    typedef struct {
        logic [3:0] rv;
        logic       mrr;
        logic       mrv;
        logic [7:0] mrd;
        logic [3:0] rdy;
        logic [3:0] rsv;
        logic [7:0] rdata;
        logic       mv;
        logic [7:0] maddr;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] req_ready;
    logic [7:0] req_addr [4];
    logic [3:0] resp_valid;
    logic [7:0] resp_data [4];
    logic       mem_req_valid;
    logic       mem_req_ready = 1'b0;
    logic [7:0] mem_req_addr;
    logic       mem_resp_valid = 1'b0;
    logic [7:0] mem_resp_data = '0;
    logic       busy;

    int vec_count = 0;
    int miss_count = 0;

    vec_t tbl [$];

    always #5 clk = ~clk;

    name_suite_vec_mem_responder dut (
        .clk                           (clk),
        .reset                         (reset),
        .io_requestor_0_req_valid      (req_valid[0]),
        .io_requestor_0_req_ready      (req_ready[0]),
        .io_requestor_0_req_bits_addr  (req_addr[0]),
        .io_requestor_0_resp_valid     (resp_valid[0]),
        .io_requestor_0_resp_bits_data (resp_data[0]),
        .io_requestor_1_req_valid      (req_valid[1]),
        .io_requestor_1_req_ready      (req_ready[1]),
        .io_requestor_1_req_bits_addr  (req_addr[1]),
        .io_requestor_1_resp_valid     (resp_valid[1]),
        .io_requestor_1_resp_bits_data (resp_data[1]),
        .io_requestor_2_req_valid      (req_valid[2]),
        .io_requestor_2_req_ready      (req_ready[2]),
        .io_requestor_2_req_bits_addr  (req_addr[2]),
        .io_requestor_2_resp_valid     (resp_valid[2]),
        .io_requestor_2_resp_bits_data (resp_data[2]),
        .io_requestor_3_req_valid      (req_valid[3]),
        .io_requestor_3_req_ready      (req_ready[3]),
        .io_requestor_3_req_bits_addr  (req_addr[3]),
        .io_requestor_3_resp_valid     (resp_valid[3]),
        .io_requestor_3_resp_bits_data (resp_data[3]),
        .io_mem_req_valid              (mem_req_valid),
        .io_mem_req_ready              (mem_req_ready),
        .io_mem_req_bits_addr          (mem_req_addr),
        .io_mem_resp_valid             (mem_resp_valid),
        .io_mem_resp_bits_data         (mem_resp_data),
        .io_busy                       (busy)
    );

    function automatic vec_t mk(logic [3:0] rv, logic mrr, logic mrv, logic [7:0] mrd,
                                logic [3:0] rdy, logic [3:0] rsv, logic [7:0] rdata,
                                logic mv, logic [7:0] maddr, logic busy_e);
        vec_t v;
        v.rv = rv; v.mrr = mrr; v.mrv = mrv; v.mrd = mrd;
        v.rdy = rdy; v.rsv = rsv; v.rdata = rdata;
        v.mv = mv; v.maddr = maddr; v.busy = busy_e;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        req_valid      = v.rv;
        mem_req_ready  = v.mrr;
        mem_resp_valid = v.mrv;
        mem_resp_data  = v.mrd;
        #1;
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        logic [57:0] got;
        logic [57:0] exp;
        got = {req_ready, resp_valid, resp_data[0], resp_data[1], resp_data[2], resp_data[3],
               mem_req_valid, mem_req_addr, busy};
        exp = {v.rdy, v.rsv, v.rdata, v.rdata, v.rdata, v.rdata, v.mv, v.maddr, v.busy};
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got rdy=%b rsv=%b data=%h/%h/%h/%h mv=%b maddr=%h busy=%b, expected rdy=%b rsv=%b data=%h mv=%b maddr=%h busy=%b",
                     name, req_ready, resp_valid, resp_data[0], resp_data[1], resp_data[2],
                     resp_data[3], mem_req_valid, mem_req_addr, busy,
                     v.rdy, v.rsv, v.rdata, v.mv, v.maddr, v.busy);
        end
    endtask

    task automatic runVec(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput(name, v);
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        reset          = 1'b1;
        req_valid      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        #1;
        checkOutput(name, mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        req_addr[0] = 8'h10; req_addr[1] = 8'h11; req_addr[2] = 8'h12; req_addr[3] = 8'h13;

        // All four ports hammering, memory always ready, one-cycle reply of addr^0xFF.
        tbl.push_back(mk(4'hF, 1, 0, 8'h00, 4'b0001, 4'b0000, 8'h00, 0, 8'h00, 0));
        tbl.push_back(mk(4'hF, 1, 0, 8'h00, 4'b0000, 4'b0000, 8'h00, 1, 8'h10, 1));
        tbl.push_back(mk(4'hF, 1, 1, 8'hEF, 4'b0000, 4'b0000, 8'h00, 0, 8'h10, 1));
        tbl.push_back(mk(4'hF, 1, 0, 8'h00, 4'b0010, 4'b0001, 8'hEF, 0, 8'h10, 0));
        tbl.push_back(mk(4'hF, 1, 0, 8'h00, 4'b0000, 4'b0000, 8'hEF, 1, 8'h11, 1));
        tbl.push_back(mk(4'hF, 1, 1, 8'hEE, 4'b0000, 4'b0000, 8'hEF, 0, 8'h11, 1));
        tbl.push_back(mk(4'hF, 1, 0, 8'h00, 4'b0100, 4'b0010, 8'hEE, 0, 8'h11, 0));
        tbl.push_back(mk(4'hF, 1, 0, 8'h00, 4'b0000, 4'b0000, 8'hEE, 1, 8'h12, 1));
        tbl.push_back(mk(4'hF, 1, 1, 8'hED, 4'b0000, 4'b0000, 8'hEE, 0, 8'h12, 1));
        tbl.push_back(mk(4'hF, 1, 0, 8'h00, 4'b1000, 4'b0100, 8'hED, 0, 8'h12, 0));
        tbl.push_back(mk(4'hF, 1, 0, 8'h00, 4'b0000, 4'b0000, 8'hED, 1, 8'h13, 1));
        tbl.push_back(mk(4'hF, 1, 1, 8'hEC, 4'b0000, 4'b0000, 8'hED, 0, 8'h13, 1));
        tbl.push_back(mk(4'hF, 1, 0, 8'h00, 4'b0001, 4'b1000, 8'hEC, 0, 8'h13, 0));
        tbl.push_back(mk(4'hF, 1, 0, 8'h00, 4'b0000, 4'b0000, 8'hEC, 1, 8'h10, 1));
        tbl.push_back(mk(4'hF, 1, 1, 8'hEF, 4'b0000, 4'b0000, 8'hEC, 0, 8'h10, 1));
        tbl.push_back(mk(4'h0, 1, 0, 8'h00, 4'b0000, 4'b0001, 8'hEF, 0, 8'h10, 0));
        tbl.push_back(mk(4'h0, 1, 0, 8'h00, 4'b0000, 4'b0000, 8'hEF, 0, 8'h10, 0));

        doReset("reset_initial");
        for (int i = 0; i < tbl.size(); i++) begin
            runVec($sformatf("rr_%0d", i), tbl[i]);
        end

        // Port 2 alone; memory stalls three cycles before taking the request.
        $display("[TB] stalled memory sequence");
        doReset("reset_stall");
        req_addr[2] = 8'h5A;
        runVec("stall_grant",  mk(4'b0100, 0, 0, 8'h00, 4'b0100, 0, 8'h00, 0, 8'h00, 0));
        for (int i = 0; i < 3; i++) begin
            runVec($sformatf("stall_hold_%0d", i), mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h5A, 1));
        end
        runVec("stall_hs",     mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h5A, 1));
        runVec("stall_wait",   mk(0, 0, 1, 8'h33, 0, 0, 8'h00, 0, 8'h5A, 1));
        runVec("stall_resp",   mk(0, 0, 0, 8'h00, 0, 4'b0100, 8'h33, 0, 8'h5A, 0));
        runVec("stall_idle",   mk(0, 0, 0, 8'h00, 0, 0, 8'h33, 0, 8'h5A, 0));

        // Spurious memory responses while IDLE and during the ISSUE handshake.
        $display("[TB] spurious response sequence");
        runVec("spur_idle",    mk(0, 0, 1, 8'h77, 0, 0, 8'h33, 0, 8'h5A, 0));
        runVec("spur_grant",   mk(4'b0001, 0, 0, 8'h00, 4'b0001, 0, 8'h33, 0, 8'h5A, 0));
        runVec("spur_issue",   mk(0, 1, 1, 8'h77, 0, 0, 8'h33, 1, 8'h10, 1));
        runVec("spur_wait",    mk(0, 0, 0, 8'h00, 0, 0, 8'h33, 0, 8'h10, 1));
        runVec("spur_real",    mk(0, 0, 1, 8'h44, 0, 0, 8'h33, 0, 8'h10, 1));
        runVec("spur_resp",    mk(0, 0, 0, 8'h00, 0, 4'b0001, 8'h44, 0, 8'h10, 0));
        runVec("spur_after",   mk(0, 0, 0, 8'h00, 0, 0, 8'h44, 0, 8'h10, 0));

        // Reset lands while port 1's transaction sits in WAIT.
        $display("[TB] reset during wait sequence");
        doReset("reset_pre_abort");
        req_addr[1] = 8'h21;
        runVec("abort_grant",  mk(4'b0010, 0, 0, 8'h00, 4'b0010, 0, 8'h00, 0, 8'h00, 0));
        runVec("abort_issue",  mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h21, 1));
        runVec("abort_wait",   mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h21, 1));
        reset = 1'b1;
        #1;
        checkOutput("abort_async", mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0));
        #1;
        reset = 1'b0;
        runVec("abort_late",   mk(0, 0, 1, 8'h99, 0, 0, 8'h00, 0, 8'h00, 0));
        runVec("abort_regr",   mk(4'b0011, 0, 0, 8'h00, 4'b0001, 0, 8'h00, 0, 8'h00, 0));
        runVec("abort_issue2", mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h10, 1));
        runVec("abort_wait2",  mk(0, 0, 1, 8'h55, 0, 0, 8'h00, 0, 8'h10, 1));
        runVec("abort_resp2",  mk(0, 0, 0, 8'h00, 0, 4'b0001, 8'h55, 0, 8'h10, 0));

        // Port 1 served, then 1 and 3 compete: 3 must win, then 1, grants back-to-back.
        $display("[TB] fairness sequence");
        doReset("reset_fair");
        req_addr[3] = 8'h23;
        runVec("fair_g1",      mk(4'b0010, 1, 0, 8'h00, 4'b0010, 0, 8'h00, 0, 8'h00, 0));
        runVec("fair_i1",      mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h21, 1));
        runVec("fair_w1",      mk(0, 1, 1, 8'hA1, 0, 0, 8'h00, 0, 8'h21, 1));
        runVec("fair_g3",      mk(4'b1010, 1, 0, 8'h00, 4'b1000, 4'b0010, 8'hA1, 0, 8'h21, 0));
        runVec("fair_i3",      mk(4'b0010, 1, 0, 8'h00, 0, 0, 8'hA1, 1, 8'h23, 1));
        runVec("fair_w3",      mk(4'b0010, 1, 1, 8'hA3, 0, 0, 8'hA1, 0, 8'h23, 1));
        runVec("fair_g1b",     mk(4'b0010, 1, 0, 8'h00, 4'b0010, 4'b1000, 8'hA3, 0, 8'h23, 0));
        runVec("fair_i1b",     mk(0, 1, 0, 8'h00, 0, 0, 8'hA3, 1, 8'h21, 1));
        runVec("fair_w1b",     mk(0, 1, 1, 8'hB1, 0, 0, 8'hA3, 0, 8'h21, 1));
        runVec("fair_r1b",     mk(0, 1, 0, 8'h00, 0, 4'b0010, 8'hB1, 0, 8'h21, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
